// File: rtl/uart_pkg.sv
// Shared UART constants and the TX FIFO launch-FSM state type.
// Imported by the TX FIFO, its interface, its storage and the bench.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS     = 8;
  localparam int unsigned UART_FIFO_DEPTH    = 16;
  localparam int unsigned UART_START_TIMEOUT = 16;

  typedef enum logic [1:0] {
    TXF_IDLE,
    TXF_WAIT_START,
    TXF_WAIT_DONE
  } txf_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host/transmitter-side bundle of the UART TX FIFO.
// master: host + transmitter side; slave: the FIFO itself.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned data_bits = UART_DATA_BITS,
  parameter int unsigned depth     = UART_FIFO_DEPTH
);
  localparam int unsigned CW = $clog2(depth) + 1;

  logic [data_bits-1:0] wr_data;
  logic                 wr_en;
  logic                 flush;
  logic                 tx_active;
  logic [data_bits-1:0] tx_data_in;
  logic                 tx_data_vld;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 start_err;

  modport master (
    output wr_data, wr_en, flush, tx_active,
    input  tx_data_in, tx_data_vld, full,
    input  empty, count, overflow, start_err
  );

  modport slave (
    input  wr_data, wr_en, flush, tx_active,
    output tx_data_in, tx_data_vld, full,
    output empty, count, overflow, start_err
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// depth x data_bits register array, one write port, async read.
// Ports: clk, we_i/waddr_i/wdata_i write, raddr_i -> rdata_o read.
module uart_fifo_mem #(
  parameter int unsigned data_bits = 8,
  parameter int unsigned depth     = 16,
  parameter int unsigned AW        = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [data_bits-1:0] wdata_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [data_bits-1:0] rdata_o
);

  logic [data_bits-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Character FIFO feeding uart_tx with a launch/handshake FSM.
// Ports: clk, rst (async, active-low), bus (uart_tx_fifo_if.slave).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned data_bits     = UART_DATA_BITS,
  parameter int unsigned depth         = UART_FIFO_DEPTH,
  parameter int unsigned start_timeout = UART_START_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW =
    (start_timeout > 1) ? $clog2(start_timeout) : 1;

  txf_state_e           state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [data_bits-1:0] dout_q, dout_d;
  logic [data_bits-1:0] head;
  logic                 vld_q, vld_d;
  logic                 ovf_q, ovf_d;
  logic                 serr_q, serr_d;
  logic                 full, empty;
  logic                 wr_ok, pop;

  assign full  = (count_q == CW'(depth));
  assign empty = (count_q == '0);
  // A pop in the same cycle does not make room for a write.
  assign wr_ok = bus.wr_en & ~full & ~bus.flush;
  assign ovf_d = bus.wr_en & full & ~bus.flush;

  uart_fifo_mem #(
    .data_bits (data_bits),
    .depth     (depth)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    vld_d   = 1'b0;
    dout_d  = dout_q;
    serr_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      TXF_IDLE: begin
        if (!empty && !bus.tx_active && !bus.flush) begin
          vld_d   = 1'b1;
          dout_d  = head;
          pop     = 1'b1;
          tmr_d   = '0;
          state_d = TXF_WAIT_START;
        end
      end
      TXF_WAIT_START: begin
        if (bus.tx_active) begin
          tmr_d   = '0;
          state_d = TXF_WAIT_DONE;
        end else if (tmr_q == TW'(start_timeout - 1)) begin
          // Transmitter never picked it up: the character is lost.
          tmr_d   = '0;
          serr_d  = 1'b1;
          state_d = TXF_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      TXF_WAIT_DONE: begin
        if (!bus.tx_active) state_d = TXF_IDLE;
      end
      default: state_d = TXF_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap by overflow.
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_ok && !pop) count_d = count_q + CW'(1);
      if (!wr_ok && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= TXF_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tmr_q    <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tmr_q    <= tmr_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      serr_q   <= serr_d;
    end
  end

  assign bus.tx_data_in  = dout_q;
  assign bus.tx_data_vld = vld_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.start_err   = serr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a queue-based reference model.
// Covers launch, overflow, ordering, timeout, flush and async reset.
module tb_uart_tx_fifo;

  localparam int DB    = 8;
  localparam int DEPTH = 16;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.data_bits(DB), .depth(DEPTH)) bus ();

  uart_tx_fifo #(
    .data_bits     (DB),
    .depth         (DEPTH),
    .start_timeout (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Transmitter stand-in: either a forced level, or busy for
  // 10 cycles after each strobe it samples.
  int   xmode    = 0;
  logic tx_level = 1'b0;
  int   busy     = 0;
  int   fc[$];
  logic sv, nx;

  initial bus.tx_active = 1'b0;

  always @(posedge clk) begin
    sv = bus.tx_data_vld;
    #1;
    if (xmode == 0) begin
      busy = 0;
      nx   = tx_level;
    end else begin
      if (sv) busy = 10;
      else if (busy > 0) busy--;
      nx = (busy > 0);
    end
    // Record the edge at which the low level is first sampled.
    if (bus.tx_active && !nx) fc.push_back(cyc + 1);
    bus.tx_active = nx;
  end

  // Reference model: a character queue plus one in-flight slot.
  logic [DB-1:0] mq[$];
  bit            m_busy, m_started;
  int            m_wait;
  logic          m_vld, m_ovf, m_err;
  logic [DB-1:0] m_data;
  bit            launch, wok;

  initial begin
    m_busy = 0; m_started = 0; m_wait = 0;
    m_vld = 0; m_ovf = 0; m_err = 0; m_data = '0;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_busy = 0; m_started = 0; m_wait = 0;
      m_vld = 0; m_ovf = 0; m_err = 0; m_data = '0;
    end else begin
      m_vld  = 0;
      m_err  = 0;
      launch = !m_busy && mq.size() > 0 &&
               !bus.tx_active && !bus.flush;
      wok    = bus.wr_en && mq.size() < DEPTH && !bus.flush;
      m_ovf  = bus.wr_en && mq.size() == DEPTH && !bus.flush;
      if (m_busy) begin
        if (!m_started) begin
          if (bus.tx_active) m_started = 1;
          else begin
            m_wait++;
            if (m_wait == TMO) begin
              m_busy = 0;
              m_err  = 1;
            end
          end
        end else if (!bus.tx_active) m_busy = 0;
      end
      if (launch) begin
        m_vld     = 1;
        m_data    = mq.pop_front();
        m_busy    = 1;
        m_started = 0;
        m_wait    = 0;
      end
      if (bus.flush) mq.delete();
      if (wok) mq.push_back(bus.wr_data);
    end
  end

  // Per-cycle compare plus event logs.
  logic [DB-1:0] lq[$];
  int lc[$];
  int ec[$];
  int n_ovf = 0;

  always @(negedge clk) begin
    check("tx_data_vld", bus.tx_data_vld, m_vld);
    check("tx_data_in", bus.tx_data_in, m_data);
    check("count", bus.count, mq.size());
    check("full", bus.full, mq.size() == DEPTH);
    check("empty", bus.empty, mq.size() == 0);
    check("overflow", bus.overflow, m_ovf);
    check("start_err", bus.start_err, m_err);
    if (bus.tx_data_vld) begin
      lq.push_back(bus.tx_data_in);
      lc.push_back(cyc);
    end
    if (bus.overflow) n_ovf++;
    if (bus.start_err) ec.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DB-1:0] d);
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    lq.delete(); lc.delete(); ec.delete(); fc.delete();
    n_ovf = 0;
  endtask

  initial begin
    bus.wr_data = '0;
    bus.wr_en   = 1'b0;
    bus.flush   = 1'b0;

    // Basic launch: written in cycle c, strobe in cycle c+2.
    xmode = 1;
    do_reset();
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    wr(8'hA5);
    check("basic_vld_c1", bus.tx_data_vld, 0);
    check("basic_count_c1", bus.count, 1);
    tick();
    check("basic_vld_c2", bus.tx_data_vld, 1);
    check("basic_data", bus.tx_data_in, 8'hA5);
    check("basic_count_c2", bus.count, 0);
    tick();
    check("basic_vld_c3", bus.tx_data_vld, 0);
    check("basic_data_hold", bus.tx_data_in, 8'hA5);
    repeat (15) tick();

    // Fill and overflow with the transmitter held busy.
    xmode = 0; tx_level = 1'b1;
    do_reset();
    for (int i = 0; i < 17; i++) wr(DB'(8'h10 + i));
    check("ovf_count", bus.count, 16);
    check("ovf_full", bus.full, 1);
    tick();
    check("ovf_pulses", n_ovf, 1);
    lq.delete();
    xmode = 1;
    repeat (260) tick();
    check("ovf_drained", lq.size(), 16);
    check("ovf_first", (lq.size() > 0) ? lq[0] : 8'h00, 8'h10);
    check("ovf_last", (lq.size() > 15) ? lq[15] : 8'h00, 8'h1F);

    // Ordering with a 10-cycle busy transmitter.
    xmode = 1;
    do_reset();
    wr(8'h01); wr(8'h02); wr(8'h03);
    repeat (60) tick();
    check("ord_n", lq.size(), 3);
    check("ord_0", (lq.size() > 2) ? lq[0] : 8'h00, 8'h01);
    check("ord_1", (lq.size() > 2) ? lq[1] : 8'h00, 8'h02);
    check("ord_2", (lq.size() > 2) ? lq[2] : 8'h00, 8'h03);
    for (int i = 0; i < 2; i++)
      check("ord_gap",
            (lc.size() > i + 1) ? lc[i+1] : -1,
            (fc.size() > i) ? fc[i] + 1 : -2);

    // Start timeout with tx_active tied low.
    xmode = 0; tx_level = 1'b0;
    do_reset();
    wr(8'h3C); wr(8'h3D);
    repeat (45) tick();
    check("tmo_first", (lq.size() > 1) ? lq[0] : 8'h00, 8'h3C);
    check("tmo_next", (lq.size() > 1) ? lq[1] : 8'h00, 8'h3D);
    check("tmo_err_at",
          (ec.size() > 0) ? ec[0] : -1,
          (lc.size() > 0) ? lc[0] + TMO : -2);
    check("tmo_relaunch",
          (lc.size() > 1) ? lc[1] : -1,
          (lc.size() > 0) ? lc[0] + TMO + 1 : -2);

    // Flush with 5 queued, 1 in flight and a same-cycle write.
    xmode = 1;
    do_reset();
    for (int i = 0; i < 6; i++) wr(DB'(8'h41 + i));
    repeat (2) tick();
    check("fl_pre_count", bus.count, 5);
    check("fl_pre_busy", bus.tx_active, 1);
    lq.delete(); n_ovf = 0;
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h99;
    tick();
    bus.flush = 1'b0; bus.wr_en = 1'b0;
    check("fl_count", bus.count, 0);
    check("fl_empty", bus.empty, 1);
    repeat (30) tick();
    check("fl_no_launch", lq.size(), 0);
    check("fl_no_ovf", n_ovf, 0);
    check("fl_no_err", ec.size(), 0);
    check("fl_done", bus.tx_active, 0);

    // Async reset in the middle of a handshake, 3 queued.
    xmode = 1;
    do_reset();
    for (int i = 0; i < 4; i++) wr(DB'(8'h51 + i));
    repeat (2) tick();
    check("rs_pre_count", bus.count, 3);
    check("rs_pre_busy", bus.tx_active, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rs_count", bus.count, 0);
    check("rs_empty", bus.empty, 1);
    check("rs_full", bus.full, 0);
    check("rs_vld", bus.tx_data_vld, 0);
    check("rs_data", bus.tx_data_in, 0);
    check("rs_ovf", bus.overflow, 0);
    check("rs_err", bus.start_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    lq.delete();
    wr(8'h77);
    repeat (30) tick();
    check("rs_after_n", lq.size(), 1);
    check("rs_after_d", (lq.size() > 0) ? lq[0] : 8'h00, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter data_bits, default 8, width of each buffered character (range 5-9).
REQ-002 SHALL have parameter depth, default 16, number of FIFO entries (power of two, 4-256).
REQ-003 SHALL have parameter start_timeout, default 16, clk cycles to wait for tx_active to rise after a launch.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_data  input  data_bits  character to enqueue.
REQ-007 SHALL have port wr_en  input  1  enqueue strobe, one character per cycle.
REQ-008 SHALL have port flush  input  1  discard all queued characters.
REQ-009 SHALL have port tx_active  input  1  busy flag from the downstream transmitter.
REQ-010 SHALL have port tx_data_in  output  data_bits  character presented to the transmitter.
REQ-011 SHALL have port tx_data_vld  output  1  single-cycle launch strobe to the transmitter.
REQ-012 SHALL have port full  output  1  count == depth.
REQ-013 SHALL have port empty  output  1  count == 0.
REQ-014 SHALL have port count  output  $clog2(depth)+1  number of queued characters.
REQ-015 SHALL have port overflow  output  1  one-cycle pulse when a write is rejected.
REQ-016 SHALL have port start_err  output  1  one-cycle pulse when start_timeout expires.

Function
REQ-017 SHALL accept wr_data on a cycle with wr_en=1, full=0, flush=0; count, full and empty update on the next edge.
REQ-018 SHALL reject a write when full=1, even if a pop occurs in the same cycle, and pulse overflow the next cycle.
REQ-019 SHALL handle simultaneous accepted write and pop by leaving count unchanged.
REQ-020 SHALL wrap read and write pointers modulo depth, using no extra storage.
REQ-021 SHALL, on flush=1, clear pointers and count on the next edge, drop any same-cycle write without an overflow pulse, and let the FSM finish any character already launched.
REQ-022 SHALL implement an FSM with states IDLE, WAIT_START and WAIT_DONE.
REQ-023 SHALL, in IDLE with empty=0, tx_active=0 and flush=0, register tx_data_vld=1 and tx_data_in=head entry, pop the head, and go to WAIT_START.
REQ-024 SHALL hold tx_data_vld high for exactly one cycle; tx_data_in SHALL hold its value until the next launch.
REQ-025 SHALL, in WAIT_START, go to WAIT_DONE when tx_active=1.
REQ-026 SHALL, in WAIT_START, return to IDLE after start_timeout cycles with tx_active=0 and pulse start_err; the character is lost.
REQ-027 SHALL, in WAIT_DONE, return to IDLE when tx_active=0.
REQ-028 SHALL give latency from an accepted write into an empty FIFO with the transmitter idle of tx_data_vld=1 two cycles after the write edge.
REQ-029 SHALL launch back-to-back characters no sooner than one cycle after tx_active falls.

Reset
REQ-030 SHALL, while rst=0, asynchronously force: FSM=IDLE, pointers=0, count=0, empty=1, full=0, tx_data_vld=0, tx_data_in=0, overflow=0, start_err=0, timeout counter=0.
REQ-031 SHALL, on reset mid-transfer, discard the queue and the in-flight handshake state; the first launch after release requires tx_active=0.
REQ-032 SHALL leave storage array contents unreset.

Structure
REQ-033 SHALL place the FSM state enum typedef in the shared package uart_pkg, together with the existing UART parameter constants.
REQ-034 SHALL use one sub-module, uart_fifo_mem: a depth x data_bits register array with one write port and a combinational read port.
REQ-035 SHALL be instantiable between host logic and uart_tx inside uart, driving tx_data_in and tx_data_vld and consuming tx_active.

Verification
REQ-036 SHALL cover basic launch: write 0xA5 into an empty FIFO, tx_active=0 -> tx_data_vld high 1 cycle, 2 cycles after the write, tx_data_in=0xA5, count returns to 0.
REQ-037 SHALL cover fill and overflow: depth=16, 17 writes with tx_active=1 held -> full=1, count=16, single overflow pulse, 17th byte absent.
REQ-038 SHALL cover ordering: write 0x01,0x02,0x03 with the transmitter model busy 10 cycles each -> launches in order 01,02,03, each launch 1 cycle after tx_active falls.
REQ-039 SHALL cover timeout: launch with tx_active tied 0 -> start_err pulse 16 cycles after entering WAIT_START, FSM back in IDLE, next byte launched.
REQ-040 SHALL cover flush: flush with 5 queued and 1 in flight plus a same-cycle write -> count=0, no overflow, in-flight handshake completes, no further launches.
REQ-041 SHALL cover reset: rst=0 asserted mid-WAIT_DONE with 3 queued -> all outputs take reset values immediately, without waiting for a clk edge.
